// File: rtl/core2wb_pkg.sv
// Shared types and constants for the Ibex-to-Wishbone pipelined bridge.
//   state_e : bridge operating mode (normal traffic or draining after an abort)
//   cnt_w() : width of a counter able to hold 0..max_pending inclusive
package core2wb_pkg;

  localparam int unsigned DEF_AW          = 32;
  localparam int unsigned DEF_DW          = 32;
  localparam int unsigned DEF_MAX_PENDING = 16;
  localparam int unsigned DEF_TIMEOUT     = 1024;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  function automatic int unsigned cnt_w(input int unsigned max_pending);
    return $clog2(max_pending + 1);
  endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Response watchdog: counts consecutive cycles in which the bridge is waiting for
// a response and flags expiry on the TIMEOUT-th such cycle.
//   clk    : clock
//   rst    : synchronous active-high reset
//   en     : waiting for a response this cycle
//   clr    : progress was made (or nothing is outstanding); restart the count
//   expire : combinational, high on the cycle the wait budget runs out
// TIMEOUT == 0 disables the watchdog entirely.
module wb_watchdog #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expire
);

  if (TIMEOUT == 0) begin : g_off
    logic w_unused;
    assign w_unused = ^{clk, rst, en, clr};
    assign expire   = 1'b0;
  end else begin : g_on
    localparam int unsigned W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [W-1:0] r_cnt;
    logic         w_hit;

    // r_cnt holds the number of waiting cycles already seen, so the current
    // waiting cycle is number r_cnt+1.
    assign w_hit  = (r_cnt == W'(TIMEOUT - 1));
    assign expire = en & w_hit;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_cnt <= '0;
      end else if (clr) begin
        r_cnt <= '0;
      end else if (en) begin
        r_cnt <= w_hit ? '0 : r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/core2wb_pipe.sv
// Bridge from the Ibex instruction/data request interface to a Wishbone B4
// pipelined master, with an outstanding-transaction limit and a response
// watchdog. On watchdog expiry the bus cycle is aborted (wb_cyc dropped) and
// every orphaned request is answered with an error response, one per cycle.
//   clk, rst                      : clock, synchronous active-high reset
//   core_req/gnt/addr/we/be/wdata : core request channel (gnt zero-latency)
//   core_rvalid/rdata/err         : core response channel (err qualified by rvalid)
//   wb_cyc/stb/adr/we/sel/dat_o   : Wishbone master request outputs
//   wb_dat_i/ack/err/stall        : Wishbone slave returns
//   pending                       : outstanding transaction count
//   timeout                       : one-cycle pulse, cycle after watchdog expiry
//   spurious                      : one-cycle pulse on ack/err with nothing pending
module core2wb_pipe
  import core2wb_pkg::*;
#(
  parameter int unsigned AW          = DEF_AW,
  parameter int unsigned DW          = DEF_DW,
  parameter int unsigned MAX_PENDING = DEF_MAX_PENDING,
  parameter int unsigned TIMEOUT     = DEF_TIMEOUT,
  parameter bit          READ_BE     = 1'b0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            core_req,
  output logic                            core_gnt,
  input  logic [AW-1:0]                   core_addr,
  input  logic                            core_we,
  input  logic [DW/8-1:0]                 core_be,
  input  logic [DW-1:0]                   core_wdata,
  output logic                            core_rvalid,
  output logic [DW-1:0]                   core_rdata,
  output logic                            core_err,
  output logic                            wb_cyc,
  output logic                            wb_stb,
  output logic [AW-1:0]                   wb_adr,
  output logic                            wb_we,
  output logic [DW/8-1:0]                 wb_sel,
  output logic [DW-1:0]                   wb_dat_o,
  input  logic [DW-1:0]                   wb_dat_i,
  input  logic                            wb_ack,
  input  logic                            wb_err,
  input  logic                            wb_stall,
  output logic [cnt_w(MAX_PENDING)-1:0]   pending,
  output logic                            timeout,
  output logic                            spurious
);

  localparam int unsigned CW = cnt_w(MAX_PENDING);

  state_e        r_state;
  state_e        w_state_d;
  logic [CW-1:0] r_pending;
  logic [CW-1:0] w_pending_d;
  logic          r_timeout;

  logic w_run;
  logic w_busy;
  logic w_any_rsp;
  logic w_rsp;
  logic w_room;
  logic w_wd_en;
  logic w_wd_clr;
  logic w_expire;

  assign w_run     = (r_state == RUN);
  assign w_busy    = (r_pending != '0);
  assign w_any_rsp = wb_ack | wb_err;
  assign w_rsp     = w_run & w_any_rsp & w_busy;
  // Registered count only: an ack in this cycle frees a slot next cycle.
  assign w_room    = (r_pending < CW'(MAX_PENDING));

  // Request path
  assign wb_stb   = w_run & core_req & w_room;
  assign core_gnt = wb_stb & ~wb_stall;
  assign wb_cyc   = w_run & (core_req | w_busy);
  assign wb_adr   = core_addr;
  assign wb_we    = core_we;
  assign wb_dat_o = core_wdata;
  assign wb_sel   = (core_we || READ_BE) ? core_be : '1;

  // Response path; in FLUSH each outstanding request is retired with an error.
  assign core_rvalid = w_run ? w_rsp : w_busy;
  assign core_err    = w_run ? wb_err : 1'b1;
  assign core_rdata  = w_run ? wb_dat_i : '0;
  assign spurious    = w_run & w_any_rsp & ~w_busy;

  assign pending = r_pending;
  assign timeout = r_timeout;

  assign w_wd_en  = w_run & w_busy & ~w_rsp;
  assign w_wd_clr = ~w_run | ~w_busy | w_rsp;

  wb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk   (clk),
    .rst   (rst),
    .en    (w_wd_en),
    .clr   (w_wd_clr),
    .expire(w_expire)
  );

  always_comb begin
    w_pending_d = r_pending;
    w_state_d   = r_state;
    case (r_state)
      RUN: begin
        if (core_gnt && !w_rsp) begin
          w_pending_d = r_pending + 1'b1;
        end else if (!core_gnt && w_rsp) begin
          w_pending_d = r_pending - 1'b1;
        end
        if (w_expire) begin
          w_state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (w_busy) begin
          w_pending_d = r_pending - 1'b1;
        end else begin
          w_state_d = RUN;
        end
      end
      default: w_state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= RUN;
      r_pending <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_pending <= w_pending_d;
      r_timeout <= w_expire;
    end
  end

endmodule

// File: tb/tb_core2wb_pipe.sv
// Bench for core2wb_pipe: directed scenarios plus a randomized run checked
// against a transaction-count reference model.
module tb_core2wb_pipe;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned BW   = DW / 8;
  localparam int unsigned MAXP = 4;
  localparam int unsigned TO   = 8;
  localparam int unsigned CW   = $clog2(MAXP + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          core_req, core_we;
  logic [AW-1:0] core_addr;
  logic [BW-1:0] core_be;
  logic [DW-1:0] core_wdata;
  logic          core_gnt, core_rvalid, core_err;
  logic [DW-1:0] core_rdata;
  logic          wb_cyc, wb_stb, wb_we;
  logic [AW-1:0] wb_adr;
  logic [BW-1:0] wb_sel;
  logic [DW-1:0] wb_dat_o, wb_dat_i;
  logic          wb_ack, wb_err, wb_stall;
  logic [CW-1:0] pending;
  logic          timeout, spurious;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: outstanding count, abort/drain mode, consecutive waiting cycles.
  int m_pend  = 0;
  bit m_flush = 1'b0;
  int m_wait  = 0;
  bit m_to    = 1'b0;

  core2wb_pipe #(
    .AW(AW), .DW(DW), .MAX_PENDING(MAXP), .TIMEOUT(TO), .READ_BE(1'b0)
  ) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_gnt(core_gnt), .core_addr(core_addr), .core_we(core_we),
    .core_be(core_be), .core_wdata(core_wdata), .core_rvalid(core_rvalid),
    .core_rdata(core_rdata), .core_err(core_err),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_adr(wb_adr), .wb_we(wb_we), .wb_sel(wb_sel),
    .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack(wb_ack), .wb_err(wb_err),
    .wb_stall(wb_stall), .pending(pending), .timeout(timeout), .spurious(spurious)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    bit rsp, gnt;
    if (rst) begin
      m_pend = 0; m_flush = 1'b0; m_wait = 0; m_to = 1'b0;
    end else if (m_flush) begin
      m_to = 1'b0;
      if (m_pend == 0) m_flush = 1'b0;
      else m_pend = m_pend - 1;
    end else begin
      rsp  = (wb_ack || wb_err) && (m_pend > 0);
      gnt  = core_req && (m_pend < int'(MAXP)) && !wb_stall;
      m_to = 1'b0;
      if (m_pend > 0 && !rsp) begin
        m_wait = m_wait + 1;
        if (m_wait == int'(TO)) begin
          m_to = 1'b1; m_flush = 1'b1; m_wait = 0;
        end
      end else begin
        m_wait = 0;
      end
      m_pend = m_pend + int'(gnt) - int'(rsp);
    end
  endtask

  task automatic drive(input logic req, input logic we, input logic [AW-1:0] addr,
                       input logic [BW-1:0] be, input logic [DW-1:0] wdata,
                       input logic ack, input logic err, input logic [DW-1:0] rdat,
                       input logic stall);
    core_req = req; core_we = we; core_addr = addr; core_be = be; core_wdata = wdata;
    wb_ack = ack; wb_err = err; wb_dat_i = rdat; wb_stall = stall;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic adv();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_reads(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 1'b0, 32'h400 + 32'(4 * i), 4'hF, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      adv();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    adv();
    adv();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({core_gnt, core_rvalid, wb_cyc, wb_stb, timeout, spurious} !== 6'b0) begin
      n_errors++;
      $display("FAIL reset_flags: got gnt/rvalid/cyc/stb/timeout/spurious=%b want 000000",
               {core_gnt, core_rvalid, wb_cyc, wb_stb, timeout, spurious});
    end
    n_checks++;
    if (pending !== '0) begin
      n_errors++; $display("FAIL reset_pending: got %0d want 0", pending);
    end
    adv();
  endtask

  task automatic test_single_read();
    drive(1'b1, 1'b0, 32'h100, 4'h3, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    n_checks++;
    if (core_gnt !== 1'b1) begin
      n_errors++; $display("FAIL read_gnt: got %b want 1", core_gnt);
    end
    n_checks++;
    if ({wb_stb, wb_cyc, wb_we, wb_adr, wb_sel} !== {1'b1, 1'b1, 1'b0, 32'h100, 4'hF}) begin
      n_errors++;
      $display("FAIL read_req: got stb=%b cyc=%b we=%b adr=%h sel=%h want 1 1 0 00000100 f",
               wb_stb, wb_cyc, wb_we, wb_adr, wb_sel);
    end
    adv();
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0);
    @(negedge clk);
    n_checks++;
    if (pending !== CW'(1)) begin
      n_errors++; $display("FAIL read_pending1: got %0d want 1", pending);
    end
    n_checks++;
    if ({core_rvalid, core_err, core_rdata} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin
      n_errors++;
      $display("FAIL read_rsp: got rvalid=%b err=%b rdata=%h want 1 0 deadbeef",
               core_rvalid, core_err, core_rdata);
    end
    adv();
    idle();
    @(negedge clk);
    n_checks++;
    if ({wb_cyc, pending} !== {1'b0, CW'(0)}) begin
      n_errors++; $display("FAIL read_done: got cyc=%b pending=%0d want 0 0", wb_cyc, pending);
    end
    adv();
  endtask

  task automatic test_back_to_back();
    int grants = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 32'h200 + 32'(4 * i), 4'h5, 32'(i), 1'b0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      if (core_gnt === 1'b1) grants++;
      if (i == 0) begin
        n_checks++;
        if (wb_sel !== 4'h5) begin
          n_errors++; $display("FAIL b2b_sel: got %h want 5", wb_sel);
        end
      end
      if (i >= 4) begin
        n_checks++;
        if ({core_gnt, wb_stb, pending} !== {1'b0, 1'b0, CW'(4)}) begin
          n_errors++;
          $display("FAIL b2b_full: got gnt=%b stb=%b pending=%0d want 0 0 4",
                   core_gnt, wb_stb, pending);
        end
      end
      adv();
    end
    n_checks++;
    if (grants != 4) begin
      n_errors++; $display("FAIL b2b_grants: got %0d want 4", grants);
    end
    drive(1'b1, 1'b1, 32'h300, 4'hF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    n_checks++;
    if ({core_gnt, core_rvalid} !== 2'b01) begin
      n_errors++;
      $display("FAIL b2b_ackcycle: got gnt=%b rvalid=%b want 0 1", core_gnt, core_rvalid);
    end
    adv();
    drive(1'b1, 1'b1, 32'h300, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    n_checks++;
    if ({core_gnt, pending} !== {1'b1, CW'(3)}) begin
      n_errors++;
      $display("FAIL b2b_freed: got gnt=%b pending=%0d want 1 3", core_gnt, pending);
    end
    adv();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      adv();
    end
    idle();
    @(negedge clk);
    n_checks++;
    if ({wb_cyc, pending} !== {1'b0, CW'(0)}) begin
      n_errors++; $display("FAIL b2b_drain: got cyc=%b pending=%0d want 0 0", wb_cyc, pending);
    end
    adv();
  endtask

  task automatic test_simultaneous();
    issue_reads(2);
    drive(1'b1, 1'b0, 32'h500, 4'hF, 32'h0, 1'b1, 1'b0, 32'h1234, 1'b0);
    @(negedge clk);
    n_checks++;
    if ({core_gnt, core_rvalid, pending} !== {1'b1, 1'b1, CW'(2)}) begin
      n_errors++;
      $display("FAIL simul_cycle: got gnt=%b rvalid=%b pending=%0d want 1 1 2",
               core_gnt, core_rvalid, pending);
    end
    adv();
    idle();
    @(negedge clk);
    n_checks++;
    if (pending !== CW'(2)) begin
      n_errors++; $display("FAIL simul_pending: got %0d want 2", pending);
    end
    adv();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      adv();
    end
    idle();
  endtask

  task automatic test_err_mid();
    logic [DW-1:0] d;
    issue_reads(3);
    for (int k = 0; k < 3; k++) begin
      d = 32'hA000_0000 + 32'(k);
      drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, (k != 1), (k == 1), d, 1'b0);
      @(negedge clk);
      n_checks++;
      if ({core_rvalid, core_err, core_rdata} !== {1'b1, (k == 1), d}) begin
        n_errors++;
        $display("FAIL errmid_rsp%0d: got rvalid=%b err=%b rdata=%h want 1 %b %h",
                 k, core_rvalid, core_err, core_rdata, (k == 1), d);
      end
      adv();
    end
    idle();
    @(negedge clk);
    n_checks++;
    if (pending !== CW'(0)) begin
      n_errors++; $display("FAIL errmid_pending: got %0d want 0", pending);
    end
    adv();
  endtask

  task automatic test_timeout();
    bit found = 1'b0, gap = 1'b0, saw_spur = 1'b0;
    int n_rsp = 0;
    issue_reads(3);
    idle();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (timeout === 1'b1) begin
        found = 1'b1;
        break;
      end
      adv();
    end
    n_checks++;
    if (!found) begin
      n_errors++; $display("FAIL to_pulse: got no timeout within 20 cycles want pulse");
    end
    n_checks++;
    if ({wb_cyc, wb_stb} !== 2'b00) begin
      n_errors++; $display("FAIL to_cyc: got cyc=%b stb=%b want 0 0", wb_cyc, wb_stb);
    end
    // Late acks are driven throughout the drain and must be ignored.
    for (int i = 0; i < 12; i++) begin
      if (i > 0) begin
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h5555_5555, 1'b0);
        @(negedge clk);
      end
      if (spurious === 1'b1) begin
        saw_spur = 1'b1;
        break;
      end
      if (core_rvalid === 1'b1) begin
        n_checks++;
        if (gap || core_err !== 1'b1 || core_rdata !== '0) begin
          n_errors++;
          $display("FAIL to_flush_rsp: got err=%b rdata=%h gap=%b want 1 00000000 0",
                   core_err, core_rdata, gap);
        end
        n_rsp++;
      end else begin
        gap = 1'b1;
      end
      adv();
    end
    n_checks++;
    if (n_rsp != 3) begin
      n_errors++; $display("FAIL to_nrsp: got %0d error responses want 3", n_rsp);
    end
    n_checks++;
    if ({saw_spur, core_rvalid, pending} !== {1'b1, 1'b0, CW'(0)}) begin
      n_errors++;
      $display("FAIL to_late_ack: got spurious=%b rvalid=%b pending=%0d want 1 0 0",
               saw_spur, core_rvalid, pending);
    end
    adv();
    idle();
  endtask

  task automatic test_reset_mid();
    issue_reads(2);
    idle();
    rst = 1'b1;
    @(negedge clk);
    adv();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({wb_cyc, core_rvalid, pending} !== {1'b0, 1'b0, CW'(0)}) begin
      n_errors++;
      $display("FAIL rstmid_state: got cyc=%b rvalid=%b pending=%0d want 0 0 0",
               wb_cyc, core_rvalid, pending);
    end
    adv();
    drive(1'b1, 1'b0, 32'h600, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    n_checks++;
    if (core_gnt !== 1'b1) begin
      n_errors++; $display("FAIL rstmid_gnt: got %b want 1", core_gnt);
    end
    adv();
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h77, 1'b0);
    @(negedge clk);
    adv();
    idle();
  endtask

  task automatic test_random(input int ncyc);
    int ack_pct = 0;
    int r;
    bit resp, e_run, e_stb, e_gnt, e_cyc, e_rv, e_spur;
    logic [BW-1:0] e_sel;
    logic [5+CW:0] o_v, e_v;
    for (int c = 0; c < ncyc; c++) begin
      if (c % 40 == 0) begin
        r = $urandom_range(0, 2);
        ack_pct = (r == 0) ? 0 : (r == 1) ? 35 : 80;
      end
      rst        = ($urandom_range(0, 199) == 0);
      core_req   = ($urandom_range(0, 99) < 60);
      core_we    = $urandom_range(0, 1) == 1;
      core_addr  = $urandom;
      core_be    = 4'($urandom);
      core_wdata = $urandom;
      wb_stall   = ($urandom_range(0, 99) < 25);
      resp       = ($urandom_range(0, 99) < ack_pct);
      wb_err     = resp && ($urandom_range(0, 9) == 0);
      wb_ack     = resp && (!wb_err || $urandom_range(0, 1) == 1);
      wb_dat_i   = $urandom;
      @(negedge clk);
      e_run  = !m_flush;
      e_stb  = e_run && core_req && (m_pend < int'(MAXP));
      e_gnt  = e_stb && !wb_stall;
      e_cyc  = e_run && (core_req || m_pend != 0);
      e_rv   = m_flush ? (m_pend != 0) : ((wb_ack || wb_err) && m_pend != 0);
      e_spur = e_run && (wb_ack || wb_err) && m_pend == 0;
      e_sel  = core_we ? core_be : {BW{1'b1}};
      o_v = {core_gnt, wb_stb, wb_cyc, core_rvalid, spurious, timeout, pending};
      e_v = {e_gnt, e_stb, e_cyc, e_rv, e_spur, m_to, CW'(m_pend)};
      n_checks++;
      if (o_v !== e_v) begin
        n_errors++;
        $display("FAIL rnd_ctrl cyc %0d: got gnt/stb/cyc/rv/spur/to/pend=%b want %b",
                 c, o_v, e_v);
      end
      if (e_stb) begin
        n_checks++;
        if ({wb_adr, wb_we, wb_sel, wb_dat_o} !== {core_addr, core_we, e_sel, core_wdata}) begin
          n_errors++;
          $display("FAIL rnd_req cyc %0d: got adr=%h we=%b sel=%h dat=%h want %h %b %h %h",
                   c, wb_adr, wb_we, wb_sel, wb_dat_o, core_addr, core_we, e_sel, core_wdata);
        end
      end
      if (e_rv) begin
        n_checks++;
        if ({core_err, core_rdata} !== {(m_flush ? 1'b1 : wb_err), (m_flush ? 32'h0 : wb_dat_i)})
        begin
          n_errors++;
          $display("FAIL rnd_rsp cyc %0d: got err=%b rdata=%h flush=%b bus_err=%b bus_dat=%h",
                   c, core_err, core_rdata, m_flush, wb_err, wb_dat_i);
        end
      end
      adv();
    end
    rst = 1'b0;
    idle();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_back_to_back();
    test_simultaneous();
    test_err_mid();
    test_timeout();
    test_reset_mid();
    test_random(1500);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/core2wb_pipe.md
Name: core2wb_pipe

Overview:
- Parametrised successor of the Ibex-core-to-Wishbone converter: bridges the Ibex instruction/data request interface to a Wishbone B4 pipelined master.
- Adds a configurable data/address width, a hard outstanding-transaction limit and a response watchdog.
- On timeout, the watchdog aborts the bus cycle and returns error responses for every orphaned request.
- One instance sits between each Ibex port (instr or data) and the interconnect.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits; must be a multiple of 8.
- MAX_PENDING, 16, maximum outstanding Wishbone transactions (>=1).
- TIMEOUT, 1024, cycles without ack/err while transactions are pending before abort; 0 disables the watchdog.
- READ_BE, 0, 1: reads drive wb_sel from core_be; 0: reads drive all-ones.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- core_req  in  1  core request.
- core_gnt  out  1  request accepted this cycle.
- core_addr  in  AW  request address.
- core_we  in  1  write enable.
- core_be  in  DW/8  byte enables.
- core_wdata  in  DW  write data.
- core_rvalid  out  1  response valid.
- core_rdata  out  DW  read data.
- core_err  out  1  response error, qualified by core_rvalid.
- wb_cyc  out  1  Wishbone cycle.
- wb_stb  out  1  Wishbone strobe.
- wb_adr  out  AW  address.
- wb_we  out  1  write enable.
- wb_sel  out  DW/8  byte select.
- wb_dat_o  out  DW  write data.
- wb_dat_i  in  DW  read data.
- wb_ack  in  1  acknowledge.
- wb_err  in  1  bus error.
- wb_stall  in  1  slave stall.
- pending  out  $clog2(MAX_PENDING+1)  outstanding count.
- timeout  out  1  one-cycle pulse on watchdog expiry.
- spurious  out  1  one-cycle pulse on ack/err received with pending==0.

Behaviour:
- Reset: sync active-high. pending=0, watchdog=0, state=RUN. All outputs registered or derived from these, so after reset: core_gnt=0, core_rvalid=0, wb_cyc=0, timeout=0, spurious=0.
- FSM states:
  - RUN: normal operation.
  - FLUSH: draining orphaned requests after a timeout.
- RUN, request path (combinational, zero latency):
  - wb_stb = core_req & (pending<MAX_PENDING).
  - wb_adr, wb_we, wb_dat_o follow core_addr, core_we, core_wdata.
  - wb_sel = core_we|READ_BE ? core_be : '1.
  - core_gnt = wb_stb & ~wb_stall.
  - wb_cyc = core_req | (pending!=0).
  - Limit check uses the registered pending; an ack in the same cycle does not unblock the grant.
- RUN, response path:
  - rsp = (wb_ack|wb_err) & (pending!=0).
  - core_rvalid = rsp; core_err = wb_err (err wins if ack and err are both high); core_rdata = wb_dat_i.
- RUN, pending counter:
  - +1 on core_gnt & ~rsp; -1 on rsp & ~core_gnt; unchanged when both or neither.
  - Never exceeds MAX_PENDING; never wraps below 0.
- Spurious response: ack/err with pending==0 is not forwarded to the core; spurious pulses for one cycle.
- Watchdog:
  - Counts when state==RUN & pending!=0 & ~rsp.
  - Clears on rsp or when pending==0.
  - When the count reaches TIMEOUT-1 with no rsp that cycle: timeout pulses next cycle and state becomes FLUSH.
  - Inactive if TIMEOUT==0.
- FLUSH:
  - wb_cyc=0, wb_stb=0, core_gnt=0.
  - wb_ack/wb_err ignored; no spurious pulses.
  - Each cycle: core_rvalid=1, core_err=1, core_rdata=0, pending -1.
  - When pending reaches 0, return to RUN the next cycle.
  - Dropping wb_cyc aborts the bus cycle per Wishbone B4.
- Reset mid-transaction: all state discarded immediately; no responses are generated for lost requests.

Decomposition:
- Package core2wb_pkg holds:
  - state_e {RUN, FLUSH};
  - function cnt_w(MAX_PENDING) returning $clog2(MAX_PENDING+1);
  - default width constants.
- One sub-module, wb_watchdog: a parametrised timeout counter with inputs en/clr and output expire. The rest stays flat.

Test Plan:
- Single read: req addr 0x100, no stall, ack one cycle later with dat_i 0xDEADBEEF -> gnt same cycle, pending 1 then 0, rvalid with rdata 0xDEADBEEF, err 0.
- Back-to-back writes, MAX_PENDING=4, slave withholds ack -> exactly 4 grants, gnt low while pending==4; one ack frees one slot the next cycle; after all acks pending returns to 0 and cyc drops.
- Simultaneous grant and ack with pending==2 -> pending stays 2; rvalid and gnt both high.
- wb_err on the 2nd of 3 outstanding reads -> rvalid/err=1 on that response only; the other two return err=0.
- TIMEOUT=8, 3 pending, no ack -> timeout pulse, cyc low, 3 consecutive err responses, pending 0, then RUN; a late ack afterwards raises spurious only.
- Reset asserted with 2 pending -> next cycle pending 0, cyc 0, no rvalid; a new request is granted normally.
